// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller slice.
//   op_e    : request opcode carried on req_op
//   state_e : controller sequencing state
package stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH    = 2'd0,
    OP_POP     = 2'd1,
    OP_REPLACE = 2'd2,
    OP_PEEK    = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/stack.sv
// Shift-register stack: one head word plus DEPTH tail words, no reset.
//   clk   : clock
//   we_i  : write in_i into head
//   me_i  : move enable (shift the whole stack)
//   md_i  : move direction, 0 = down (push), 1 = up (pop)
//   in_i  : write data
//   top_o : current head word
module stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             me_i,
  input  logic             md_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] top_o
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q [DEPTH];

  assign top_o = head_q;

  always_ff @(posedge clk) begin
    if (me_i) begin
      if (md_i) begin
        // Shift up; zero fills from the bottom so repeated pops clear storage.
        head_q <= tail_q[0];
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          tail_q[i] <= tail_q[i+1];
        end
        tail_q[DEPTH-1] <= '0;
      end else begin
        // Shift down; the bottom tail word falls off the end.
        head_q <= we_i ? in_i : head_q;
        tail_q[0] <= head_q;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          tail_q[i] <= tail_q[i-1];
        end
      end
    end else if (we_i) begin
      head_q <= in_i;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Request/response controller around a shift-register stack.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_op, req_data    : opcode (PUSH/POP/REPLACE/PEEK) and write data
//   flush               : pulse to start clearing the stack
//   clr_err             : clear sticky ovf/unf
//   rsp_valid/data/err  : one-cycle response, err on empty-stack access
//   count, empty, full  : occupancy
//   ovf, unf            : sticky overflow/underflow
//   busy                : flush in progress
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 10,
  parameter bit          OVERWRITE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [WIDTH-1:0]          req_data,
  input  logic                      flush,
  input  logic                      clr_err,
  output logic                      rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic [$clog2(DEPTH+2)-1:0] count,
  output logic                      empty,
  output logic                      full,
  output logic                      ovf,
  output logic                      unf,
  output logic                      busy
);

  localparam int unsigned CAP = DEPTH + 1;
  localparam int unsigned CW  = $clog2(CAP + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    fcnt_q, fcnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             st_we, st_me, st_md;
  logic [WIDTH-1:0] st_top;
  logic             ovf_set, unf_set;
  logic             is_empty, is_full;
  op_e              op;

  assign op       = op_e'(req_op);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(CAP));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    fcnt_d      = fcnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    st_we       = 1'b0;
    st_me       = 1'b0;
    st_md       = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    req_ready   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = !flush && !(op == OP_PUSH && is_full && !OVERWRITE);
        if (flush) begin
          state_d = ST_FLUSH;
          fcnt_d  = '0;
          count_d = '0;
        end else if (req_valid && req_ready) begin
          unique case (op)
            OP_PUSH: begin
              st_we = 1'b1;
              st_me = 1'b1;
              if (is_full) ovf_set = 1'b1;
              else         count_d = count_q + CW'(1);
            end
            OP_POP: begin
              rsp_valid_d = 1'b1;
              if (is_empty) begin
                rsp_err_d = 1'b1;
                unf_set   = 1'b1;
              end else begin
                st_me      = 1'b1;
                st_md      = 1'b1;
                count_d    = count_q - CW'(1);
                rsp_data_d = st_top;
              end
            end
            OP_REPLACE: begin
              rsp_valid_d = 1'b1;
              st_we       = 1'b1;
              if (is_empty) begin
                // Acts as a push so the new word becomes the only entry.
                st_me     = 1'b1;
                count_d   = CW'(1);
                rsp_err_d = 1'b1;
                unf_set   = 1'b1;
              end else begin
                rsp_data_d = st_top;
              end
            end
            OP_PEEK: begin
              rsp_valid_d = 1'b1;
              if (is_empty) begin
                rsp_err_d = 1'b1;
                unf_set   = 1'b1;
              end else begin
                rsp_data_d = st_top;
              end
            end
            default: ;
          endcase
        end
      end
      ST_FLUSH: begin
        // CAP upward shifts push zeros through every head/tail word.
        st_me = 1'b1;
        st_md = 1'b1;
        if (fcnt_q == CW'(CAP - 1)) state_d = ST_IDLE;
        else                        fcnt_d  = fcnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    ovf_d = ovf_set | (ovf_q & ~clr_err);
    unf_d = unf_set | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      fcnt_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      fcnt_q      <= fcnt_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .we_i  (st_we),
    .me_i  (st_me),
    .md_i  (st_md),
    .in_i  (req_data),
    .top_o (st_top)
  );

  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign busy      = (state_q == ST_FLUSH);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl (WIDTH=16, DEPTH=3, CAP=4). Two instances
// share stimulus: dut uses OVERWRITE=1, dut0 uses OVERWRITE=0.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [15:0] req_data = '0;
  logic        flush = 1'b0;
  logic        clr_err = 1'b0;

  logic        req_ready, rsp_valid, rsp_err, empty, full, ovf, unf, busy;
  logic [15:0] rsp_data;
  logic [2:0]  count;

  logic        req_ready0, rsp_valid0, rsp_err0, empty0, full0, ovf0, unf0, busy0;
  logic [15:0] rsp_data0;
  logic [2:0]  count0;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] PUSH = 2'd0, POP = 2'd1, REPL = 2'd2, PEEK = 2'd3;

  always #5 clk = ~clk;

  stack_ctrl #(.WIDTH(16), .DEPTH(3), .OVERWRITE(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .flush(flush), .clr_err(clr_err),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf), .busy(busy)
  );

  stack_ctrl #(.WIDTH(16), .DEPTH(3), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_op(req_op), .req_data(req_data), .flush(flush), .clr_err(clr_err),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_err(rsp_err0),
    .count(count0), .empty(empty0), .full(full0), .ovf(ovf0), .unf(unf0), .busy(busy0)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; clr_err = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // One request held for exactly one edge; outputs afterwards show its response.
  task automatic req(input logic [1:0] op, input logic [15:0] d);
    req_valid = 1'b1; req_op = op; req_data = d;
    cyc();
    req_valid = 1'b0; req_data = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({count, empty, full, ovf, unf, busy} !== {3'd0, 5'b10000}) begin
      errors++;
      $display("FAIL reset_flags: got count=%0d e/f/o/u/b=%b required count=0 e/f/o/u/b=10000",
               count, {empty, full, ovf, unf, busy});
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, req_ready} !== {2'b00, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b e=%b d=%h rdy=%b required v=0 e=0 d=0000 rdy=1",
               rsp_valid, rsp_err, rsp_data, req_ready);
    end
  endtask

  task automatic test_lifo();
    logic [15:0] exp [3];
    exp[0] = 16'h3333; exp[1] = 16'h2222; exp[2] = 16'h1111;
    do_reset();
    req(PUSH, 16'h1111);
    req(PUSH, 16'h2222);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL push_no_rsp: got rsp_valid=%b required 0", rsp_valid);
    end
    req(PUSH, 16'h3333);
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL lifo_count: got %0d required 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      req(POP, 16'h0);
      checks++;
      if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, exp[i]}) begin
        errors++;
        $display("FAIL lifo_pop%0d: got v=%b e=%b d=%h required v=1 e=0 d=%h",
                 i, rsp_valid, rsp_err, rsp_data, exp[i]);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL lifo_empty: got %b required 1", empty);
    end
    cyc();
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== 18'h0) begin
      errors++;
      $display("FAIL idle_rsp_zero: got v=%b e=%b d=%h required all 0", rsp_valid, rsp_err, rsp_data);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    for (int i = 1; i <= 4; i++) req(PUSH, 16'(i));
    checks++;
    if ({full, ovf, count} !== {2'b10, 3'd4}) begin
      errors++; $display("FAIL ow_full4: got full=%b ovf=%b count=%0d required 1 0 4", full, ovf, count);
    end
    req(PUSH, 16'd5);
    checks++;
    if ({full, ovf, count} !== {2'b11, 3'd4}) begin
      errors++; $display("FAIL ow_push5: got full=%b ovf=%b count=%0d required 1 1 4", full, ovf, count);
    end
    for (int i = 0; i < 4; i++) begin
      req(POP, 16'h0);
      checks++;
      if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 16'(5 - i)}) begin
        errors++;
        $display("FAIL ow_pop%0d: got v=%b e=%b d=%h required v=1 e=0 d=%h",
                 i, rsp_valid, rsp_err, rsp_data, 16'(5 - i));
      end
    end
    req(POP, 16'h0);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, unf} !== {2'b11, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL ow_pop_empty: got v=%b e=%b d=%h unf=%b required 1 1 0000 1",
               rsp_valid, rsp_err, rsp_data, unf);
    end
    // Underflow set together with clear: set wins; ovf is cleared.
    clr_err = 1'b1;
    req(POP, 16'h0);
    clr_err = 1'b0;
    checks++;
    if ({ovf, unf} !== 2'b01) begin
      errors++; $display("FAIL clr_vs_set: got ovf=%b unf=%b required 0 1", ovf, unf);
    end
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    checks++;
    if ({ovf, unf} !== 2'b00) begin
      errors++; $display("FAIL clr_err: got ovf=%b unf=%b required 0 0", ovf, unf);
    end
  endtask

  task automatic test_no_overwrite();
    do_reset();
    for (int i = 1; i <= 4; i++) req(PUSH, 16'(i));
    req_valid = 1'b1; req_op = PUSH; req_data = 16'h9;
    #1;
    checks++;
    if (req_ready0 !== 1'b0) begin
      errors++; $display("FAIL no_ow_ready: got %b required 0", req_ready0);
    end
    cyc();
    req_op = POP; req_data = '0;
    #1;
    checks++;
    if ({count0, ovf0, req_ready0} !== {3'd4, 2'b01}) begin
      errors++;
      $display("FAIL no_ow_state: got count=%0d ovf=%b pop_ready=%b required 4 0 1",
               count0, ovf0, req_ready0);
    end
    cyc();
    req_valid = 1'b0;
    checks++;
    if ({rsp_valid0, rsp_data0, count0} !== {1'b1, 16'h4, 3'd3}) begin
      errors++;
      $display("FAIL no_ow_pop: got v=%b d=%h count=%0d required 1 0004 3", rsp_valid0, rsp_data0, count0);
    end
  endtask

  task automatic test_replace();
    do_reset();
    req(PUSH, 16'hA);
    req(PUSH, 16'hB);
    req(REPL, 16'hC);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, count} !== {2'b10, 16'hB, 3'd2}) begin
      errors++;
      $display("FAIL replace: got v=%b e=%b d=%h count=%0d required 1 0 000b 2",
               rsp_valid, rsp_err, rsp_data, count);
    end
    req(POP, 16'h0);
    checks++;
    if (rsp_data !== 16'hC) begin
      errors++; $display("FAIL repl_pop1: got %h required 000c", rsp_data);
    end
    req(POP, 16'h0);
    checks++;
    if (rsp_data !== 16'hA) begin
      errors++; $display("FAIL repl_pop2: got %h required 000a", rsp_data);
    end
    req(REPL, 16'h55);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, count, unf} !== {2'b11, 16'h0, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL repl_empty: got v=%b e=%b d=%h count=%0d unf=%b required 1 1 0000 1 1",
               rsp_valid, rsp_err, rsp_data, count, unf);
    end
    req(PEEK, 16'h0);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, count} !== {2'b10, 16'h55, 3'd1}) begin
      errors++;
      $display("FAIL peek: got v=%b e=%b d=%h count=%0d required 1 0 0055 1",
               rsp_valid, rsp_err, rsp_data, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [7];
    logic [15:0] din [7];
    logic        rv  [7];
    logic [15:0] rd  [7];
    logic [2:0]  cnt [7];
    ops = '{PUSH, PUSH, POP, PUSH, PEEK, POP, POP};
    din = '{16'h5, 16'h6, 16'h0, 16'h7, 16'h0, 16'h0, 16'h0};
    rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    rd  = '{16'h0, 16'h0, 16'h6, 16'h0, 16'h7, 16'h7, 16'h5};
    cnt = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd1, 3'd0};
    do_reset();
    req_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req_op = ops[i]; req_data = din[i];
      cyc();
      checks++;
      if ({rsp_valid, rsp_data, count} !== {rv[i], rd[i], cnt[i]}) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b d=%h count=%0d required v=%b d=%h count=%0d",
                 i, rsp_valid, rsp_data, count, rv[i], rd[i], cnt[i]);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_flush();
    int n;
    do_reset();
    req(PUSH, 16'h1);
    req(PUSH, 16'h2);
    req(PUSH, 16'h3);
    flush = 1'b1; req_valid = 1'b1; req_op = PUSH; req_data = 16'h99;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL flush_prio_ready: got %b required 0", req_ready);
    end
    cyc();
    flush = 1'b0; req_valid = 1'b0; req_data = '0;
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      n++;
      flush = (n == 2);
      cyc();
    end
    flush = 1'b0;
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL flush_busy_len: got %0d cycles required 4", n);
    end
    checks++;
    if ({count, busy, req_ready} !== {3'd0, 2'b01}) begin
      errors++; $display("FAIL flush_end: got count=%0d busy=%b rdy=%b required 0 0 1", count, busy, req_ready);
    end
    req(PUSH, 16'h7);
    req(POP, 16'h0);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 16'h7}) begin
      errors++; $display("FAIL flush_pop7: got v=%b e=%b d=%h required 1 0 0007", rsp_valid, rsp_err, rsp_data);
    end
    req(POP, 16'h0);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 16'h0}) begin
      errors++; $display("FAIL flush_pop_empty: got v=%b e=%b d=%h required 1 1 0000", rsp_valid, rsp_err, rsp_data);
    end
  endtask

  task automatic test_rst_in_flush();
    do_reset();
    req(PUSH, 16'h1);
    req(PUSH, 16'h2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({busy, count, req_ready} !== {1'b0, 3'd0, 1'b1}) begin
      errors++; $display("FAIL rst_in_flush: got busy=%b count=%0d rdy=%b required 0 0 1", busy, count, req_ready);
    end
    req(PEEK, 16'h0);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, unf} !== {2'b11, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL rst_peek: got v=%b e=%b d=%h unf=%b required 1 1 0000 1", rsp_valid, rsp_err, rsp_data, unf);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lifo();
    test_overwrite();
    test_no_overwrite();
    test_replace();
    test_back_to_back();
    test_flush();
    test_rst_in_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
